fft_sdf_stage: RTL and testbench

FFT_SDF_STAGE -- requirements
Module: fft_sdf_stage

---
 rtl/fft_sdf_stage_if.sv | 23 ++
 rtl/fft_sdf_stage.sv | 190 +++++++++++++++++++
 tb/tb_fft_sdf_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_sdf_stage_if.sv
// fft_sdf_stage_if: sample stream into and out of one SDF FFT stage.
// master feeds samples in; slave (the stage) returns butterfly results.
interface fft_sdf_stage_if #(
   parameter int DW = 18
);
   logic                in_valid;
   logic                in_sof;
   logic [2*DW-1:0]     in_data;
   logic                out_valid;
   logic                out_sof;
   logic [2*(DW+1)-1:0] out_data;
   logic                out_err;

   modport master (
      output in_valid, in_sof, in_data,
      input  out_valid, out_sof, out_data, out_err
   );

   modport slave (
      input  in_valid, in_sof, in_data,
      output out_valid, out_sof, out_data, out_err
   );
endinterface

// File: rtl/fft_sdf_stage.sv
// fft_sdf_stage: radix-2 single-path delay-feedback FFT stage, 3-cycle latency.
// Define FFT_SDF_ROUND_EN for round-half-up twiddle scaling (floor otherwise).
module fft_sdf_stage #(
   parameter int N  = 8,
   parameter int DW = 18,
   parameter int TW = 16
) (
   input  logic           clk,
   input  logic           rstn,
   fft_sdf_stage_if.slave bus_io
);
   localparam int LN = $clog2(N);
   localparam int HN = N / 2;
   localparam int KW = LN - 1;
   localparam int OW = DW + 1;
   localparam int PW = OW + TW + 1;
   localparam int SH = TW - 2;

   typedef logic signed [OW-1:0] ow_t;
   typedef logic signed [PW-1:0] pw_t;

   localparam real PI = 3.14159265358979323846;
   localparam real SC = 2.0 ** SH;
   localparam pw_t HI = (pw_t'(1) <<< (OW - 1)) - pw_t'(1);
   localparam pw_t LO = -(pw_t'(1) <<< (OW - 1));
`ifdef FFT_SDF_ROUND_EN
   localparam pw_t RND = pw_t'(1) <<< (SH - 1);
`else
   localparam pw_t RND = '0;
`endif

   function automatic logic signed [TW-1:0] tw_rnd(input real x);
      real r;
      r = (x >= 0.0) ? x + 0.5 : x - 0.5;
      return TW'($rtoi(r));
   endfunction

   function automatic ow_t sat(input pw_t v);
      if (v > HI) return ow_t'(HI);
      if (v < LO) return ow_t'(LO);
      return ow_t'(v);
   endfunction

   logic signed [TW-1:0] wr_rom [HN];
   logic signed [TW-1:0] wi_rom [HN];

   for (genvar g = 0; g < HN; g++) begin : g_rom
      assign wr_rom[g] = tw_rnd(SC * $cos(2.0 * PI * g / N));
      assign wi_rom[g] = -tw_rnd(SC * $sin(2.0 * PI * g / N));
   end

   logic [LN-1:0]   cnt_q, cnt_d;
   logic            primed_q, primed_d;
   logic            acc, rsync, ph_b;
   logic [LN-1:0]   idx;
   logic [KW-1:0]   k;
   ow_t             xr, xi, ar, ai;
   ow_t             sr, si, dr_n, di_n;
   logic [2*OW-1:0] wdat;
   logic [2*OW-1:0] mem_q [HN];
   pw_t             pr, pim;
   logic signed [TW-1:0] wr, wi;

   assign acc   = bus_io.in_valid;
   assign rsync = acc & bus_io.in_sof & (cnt_q != '0);
   assign idx   = bus_io.in_sof ? '0 : cnt_q;
   assign k     = idx[KW-1:0];
   assign ph_b  = idx[LN-1];

   assign xr = ow_t'($signed(bus_io.in_data[DW-1:0]));
   assign xi = ow_t'($signed(bus_io.in_data[2*DW-1:DW]));

   assign {ai, ar} = mem_q[k];

   assign sr   = ar + xr;
   assign si   = ai + xi;
   assign dr_n = ar - xr;
   assign di_n = ai - xi;
   assign wdat = ph_b ? {di_n, dr_n} : {xi, xr};

   assign wr  = wr_rom[k];
   assign wi  = wi_rom[k];
   assign pr  = pw_t'(ar) * pw_t'(wr) - pw_t'(ai) * pw_t'(wi);
   assign pim = pw_t'(ar) * pw_t'(wi) + pw_t'(ai) * pw_t'(wr);

   // frame position and primed flag; resync forces index 0
   always_comb begin
      cnt_d    = cnt_q;
      primed_d = primed_q;
      if (acc) begin
         cnt_d = idx + LN'(1);
         if (rsync)
            primed_d = 1'b0;
         else if (idx == LN'(N - 1))
            primed_d = 1'b1;
      end
   end

   // counter and primed state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q    <= '0;
         primed_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
      end
   end

   // delay line: phase A parks x, phase B parks a-b
   always_ff @(posedge clk) begin
      if (acc) mem_q[k] <= wdat;
   end

   logic        s1_v_q, s1_sof_q, s1_err_q, s1_b_q;
   pw_t         s1_pr_q, s1_pi_q;
   ow_t         s1_sr_q, s1_si_q;

   // multiply register: twiddle product, sum carried alongside
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_v_q   <= 1'b0;
         s1_sof_q <= 1'b0;
         s1_err_q <= 1'b0;
         s1_b_q   <= 1'b0;
         s1_pr_q  <= '0;
         s1_pi_q  <= '0;
         s1_sr_q  <= '0;
         s1_si_q  <= '0;
      end else begin
         s1_v_q   <= acc & (ph_b | (primed_q & ~rsync));
         s1_sof_q <= acc & ph_b & (k == '0);
         s1_err_q <= rsync;
         s1_b_q   <= ph_b;
         s1_pr_q  <= pr;
         s1_pi_q  <= pim;
         s1_sr_q  <= sr;
         s1_si_q  <= si;
      end
   end

   pw_t             rr, ri;
   logic [2*OW-1:0] s2_d;

   assign rr   = (s1_pr_q + RND) >>> SH;
   assign ri   = (s1_pi_q + RND) >>> SH;
   assign s2_d = s1_b_q ? {s1_si_q, s1_sr_q}
                        : {sat(ri), sat(rr)};

   logic            s2_v_q, s2_sof_q, s2_err_q;
   logic [2*OW-1:0] s2_d_q;

   // scale register: shift, saturate, select path
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_v_q   <= 1'b0;
         s2_sof_q <= 1'b0;
         s2_err_q <= 1'b0;
         s2_d_q   <= '0;
      end else begin
         s2_v_q   <= s1_v_q;
         s2_sof_q <= s1_sof_q;
         s2_err_q <= s1_err_q;
         s2_d_q   <= s2_d;
      end
   end

   logic            out_v_q, out_sof_q, out_err_q;
   logic [2*OW-1:0] out_d_q;

   // output register; data holds between valid beats
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_v_q   <= 1'b0;
         out_sof_q <= 1'b0;
         out_err_q <= 1'b0;
         out_d_q   <= '0;
      end else begin
         out_v_q   <= s2_v_q;
         out_sof_q <= s2_sof_q;
         out_err_q <= s2_err_q;
         if (s2_v_q) out_d_q <= s2_d_q;
      end
   end

   assign bus_io.out_valid = out_v_q;
   assign bus_io.out_sof   = out_sof_q;
   assign bus_io.out_err   = out_err_q;
   assign bus_io.out_data  = out_d_q;
endmodule

// File: tb/tb_fft_sdf_stage.sv
// tb_fft_sdf_stage: directed scoreboard bench for fft_sdf_stage.
// Expected outputs come from a behavioural SDF model using real math.
module tb_fft_sdf_stage;
   localparam int N  = 8;
   localparam int DW = 18;
   localparam int TW = 16;
   localparam int OW = DW + 1;
   localparam int HN = N / 2;

   logic clk = 1'b0;
   logic rstn;

   fft_sdf_stage_if #(.DW(DW)) bus ();

   fft_sdf_stage #(.N(N), .DW(DW), .TW(TW)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic            v;
      logic            sof;
      logic            err;
      logic [2*OW-1:0] d;
      int              due;
   } exp_t;

   exp_t   q[$];
   int     errors = 0;
   int     checks = 0;
   longint m_dr[HN];
   longint m_di[HN];
   int     m_cnt;
   bit     m_primed;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint rnd(input real x);
      if (x >= 0.0) return longint'($floor(x + 0.5));
      return -longint'($floor(-x + 0.5));
   endfunction

   function automatic longint scale(input longint p);
      real    y;
      longint r;
      y = real'(p) / 16384.0;
`ifdef FFT_SDF_ROUND_EN
      y = y + 0.5;
`endif
      r = longint'($floor(y));
      if (r > (longint'(1) << DW) - 1) r = (longint'(1) << DW) - 1;
      if (r < -(longint'(1) << DW)) r = -(longint'(1) << DW);
      return r;
   endfunction

   function automatic logic [2*OW-1:0] pack(input longint re,
                                            input longint im);
      logic [OW-1:0] r, i;
      r = re[OW-1:0];
      i = im[OW-1:0];
      return {i, r};
   endfunction

   task automatic model_reset();
      m_cnt    = 0;
      m_primed = 0;
      for (int i = 0; i < HN; i++) begin
         m_dr[i] = 0;
         m_di[i] = 0;
      end
   endtask

   task automatic send(input longint re, input longint im, input bit sof);
      int     idx, k;
      bit     rs;
      exp_t   e;
      longint wr, wi, pr, p_i, ar, ai;
      real    ang;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      bus.in_data  = {im[DW-1:0], re[DW-1:0]};
      rs    = sof && (m_cnt != 0);
      idx   = sof ? 0 : m_cnt;
      k     = idx % HN;
      e.v   = 1'b0;
      e.sof = 1'b0;
      e.err = rs;
      e.d   = '0;
      e.due = cyc + 3;
      ar    = m_dr[k];
      ai    = m_di[k];
      if (idx < HN) begin
         if (m_primed && !rs) begin
            ang = 2.0 * 3.14159265358979 * k / N;
            wr  = rnd(16384.0 * $cos(ang));
            wi  = -rnd(16384.0 * $sin(ang));
            pr  = ar * wr - ai * wi;
            p_i = ar * wi + ai * wr;
            e.v = 1'b1;
            e.d = pack(scale(pr), scale(p_i));
         end
         m_dr[k] = re;
         m_di[k] = im;
      end else begin
         e.v     = 1'b1;
         e.sof   = (idx == HN);
         e.d     = pack(ar + re, ai + im);
         m_dr[k] = ar - re;
         m_di[k] = ai - im;
      end
      if (e.v || e.err) q.push_back(e);
      if (rs) m_primed = 0;
      else if (idx == N - 1) m_primed = 1;
      m_cnt = (idx + 1) % N;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_sof   = 1'($urandom_range(0, 1));
         bus.in_data  = 36'($urandom());
      end
   endtask

   function automatic longint rs18();
      return longint'($urandom_range(0, (1 << DW) - 1))
             - (longint'(1) << (DW - 1));
   endfunction

   task automatic check_reset_outs(input string tag);
      check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
      check({tag, "_sof"}, 64'(bus.out_sof), 64'(0));
      check({tag, "_err"}, 64'(bus.out_err), 64'(0));
      check({tag, "_data"}, 64'(bus.out_data), 64'(0));
   endtask

   // scoreboard: every output slot pops one expectation
   always @(negedge clk) begin
      exp_t e;
      if (rstn === 1'b1) begin
         while (q.size() != 0 && q[0].due < cyc) begin
            e = q.pop_front();
            check("missed_output", 64'(cyc), 64'(e.due));
         end
         if (bus.out_valid === 1'b1 || bus.out_err === 1'b1) begin
            if (q.size() == 0) begin
               check("extra_output",
                     {62'd0, bus.out_valid, bus.out_err}, 64'd0);
            end else begin
               e = q.pop_front();
               check("out_cycle", 64'(cyc), 64'(e.due));
               check("out_valid", 64'(bus.out_valid), 64'(e.v));
               check("out_sof", 64'(bus.out_sof), 64'(e.sof));
               check("out_err", 64'(bus.out_err), 64'(e.err));
               if (e.v) check("out_data", 64'(bus.out_data), 64'(e.d));
            end
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_data  = '0;
      rstn         = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outs("reset");
      rstn = 1'b1;
      idle(2);

      // impulse frame then zero frame
      send(1000, 0, 1);
      repeat (7) send(0, 0, 0);
      send(0, 0, 1);
      repeat (7) send(0, 0, 0);

      // constant 100 for two frames
      for (int i = 0; i < 16; i++) send(100, 0, (i % N) == 0);

      // impulse at k=1 exercises the 45-degree twiddle
      for (int i = 0; i < N; i++) send(i == 1 ? 1000 : 0, 0, i == 0);
      for (int i = 0; i < N; i++) send(0, 0, i == 0);

      // full-scale complex frames drive saturation
      for (int i = 0; i < 2 * N; i++) send(rs18(), rs18(), (i % N) == 0);
      for (int i = 0; i < N; i++) send(0, 0, 0);

      // impulse stimulus with random input gaps
      for (int i = 0; i < 2 * N; i++) begin
         idle($urandom_range(0, 3));
         send(i == 0 ? 1000 : 0, 0, (i % N) == 0);
      end

      // resync at cnt=3
      send(5, 7, 1);
      send(11, -3, 0);
      send(-20, 4, 0);
      send(300, -300, 1);
      for (int i = 1; i < N; i++) send(10 * i, -i, 0);
      for (int i = 0; i < N; i++) send(-i, 2 * i, i == 0);

      // reset mid-stream drops in-flight outputs
      for (int i = 0; i < 5; i++) send(40 + i, 3, i == 0);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check_reset_outs("midreset");
      q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // first sample after release is index 0 without in_sof
      for (int i = 0; i < 2 * N; i++) send(i == 2 ? 500 : i, -i, 0);
      send(0, 0, 0);

      idle(6);
      check("drain", 64'(q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
